addsub_seq: RTL and testbench
=============================

ADDSUB_SEQ -- requirements
Module: addsub_seq

Parameters
REQ-001 WIDTH, 8, operand/result width in bits; SHALL be >= 2.
REQ-002 CHUNK, 4, bits processed per clock; SHALL divide WIDTH exactly; N = WIDTH/CHUNK passes per operation.

Interface
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled on rising edge.
REQ-006 mode  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start.
REQ-007 a  input  WIDTH  operand A, captured with start.
REQ-008 b  input  WIDTH  operand B, captured with start.
REQ-009 sum  output  WIDTH  registered result.
REQ-010 c_out  output  1  add: unsigned carry out; subtract: unsigned borrow (1 when a < b).
REQ-011 ovf  output  1  two's-complement signed overflow of the operation.
REQ-012 busy  output  1  high while operation in progress (RUN).
REQ-013 done  output  1  one-cycle pulse when sum/c_out/ovf are updated.

Function
REQ-014 FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both decoded from state register.
REQ-015 IDLE: start=1 on edge -> capture a, b, mode into internal registers, carry register := mode, pass counter := 0, go RUN; start=0 -> stay IDLE.
REQ-016 Subtraction SHALL be computed as a + ~b + 1 (carry-in = 1 from REQ-015); no separate subtractor.
REQ-017 RUN: each edge adds the least-significant CHUNK bits of captured A and (B or ~B) plus carry register, stores the CHUNK-bit partial into the working result, shifts operands right by CHUNK, updates carry register, increments counter.
REQ-018 RUN: on the edge where counter == N-1 the final chunk is processed, sum/c_out/ovf are loaded, state -> DONE; total N edges in RUN.
REQ-019 Latency: start sampled on edge k -> done high during the cycle following edge k+N; results valid in that same cycle.
REQ-020 c_out final = carry out of MSB for add; = inverted carry out of MSB for subtract.
REQ-021 ovf final = carry into MSB XOR carry out of MSB (equivalently, operand signs equal after B inversion and result sign differs).
REQ-022 DONE lasts exactly one cycle; start=1 on that edge -> capture new operands and go RUN (back-to-back); else -> IDLE.
REQ-023 start while in RUN SHALL be ignored; captured operands and mode SHALL not change.
REQ-024 Changes on a, b, mode outside the capture edge SHALL not affect the operation in progress.
REQ-025 sum, c_out, ovf SHALL change only on the edge entering DONE and SHALL hold their values otherwise, including through IDLE and a following RUN.
REQ-026 N = 1 (CHUNK = WIDTH) SHALL be supported: one RUN cycle, then DONE.
REQ-027 Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-028 rst_n low SHALL immediately, without a clock, force state IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, counter=0, internal operand/carry registers = 0.
REQ-029 Reset asserted during RUN SHALL abort the operation; no done pulse and no result update SHALL follow the release.
REQ-030 After rst_n release the first start is accepted on the first rising edge on which it is sampled high.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-031 a=0x02, b=0x03, mode=0, start pulse -> busy for 2 cycles, done pulse; sum=0x05, c_out=0, ovf=0.
REQ-032 a=0x02, b=0x03, mode=1 -> sum=0xFF, c_out=1 (borrow), ovf=0; a=0x80, b=0x01, mode=1 -> sum=0x7F, c_out=0, ovf=1.
REQ-033 a=0x7F, b=0x01, mode=0 -> sum=0x80, c_out=0, ovf=1; a=0xFF, b=0x01, mode=0 -> sum=0x00, c_out=1, ovf=0.
REQ-034 start held high continuously with operands changing each cycle -> operations back-to-back, one done every 3 cycles, each result matches operands present on its capture edge; start/operand changes during RUN have no effect.
REQ-035 Reset pulled low mid-RUN, no clock edge -> all outputs 0 at once; after release no done until a new start.
REQ-036 Exhaustive sweep of all a, b, mode at WIDTH=8 for CHUNK = 1, 2, 4, 8 -> every sum/c_out/ovf matches a reference model; done exactly WIDTH/CHUNK cycles after start.

Source files
------------

// File: rtl/addsub_seq.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per clock over WIDTH/CHUNK
// passes, subtracting as a + ~b + 1, and reports carry/borrow and signed overflow.
module addsub_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic               mode_q, mode_d, carry_q, carry_d;
  logic               c_out_q, c_out_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CHUNK-1:0]       chunk_a, chunk_b;
  logic [CHUNK:0]         part;
  logic [WIDTH+CHUNK-1:0] res_wide;
  logic                   capture;

  always_comb begin
    chunk_a  = a_q[CHUNK-1:0];
    chunk_b  = b_q[CHUNK-1:0] ^ {CHUNK{mode_q}};
    part     = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    // New partial enters at the top so the LSB chunk ends at bit 0 after N passes.
    res_wide = {part[CHUNK-1:0], res_q};
    capture  = start && ((state_q == IDLE) || (state_q == DONE));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_wide[WIDTH+CHUNK-1:CHUNK];
        carry_d = part[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          sum_d   = res_wide[WIDTH+CHUNK-1:CHUNK];
          c_out_d = part[CHUNK] ^ mode_q;
          ovf_d   = (chunk_a[CHUNK-1] == chunk_b[CHUNK-1]) &&
                    (part[CHUNK-1] != chunk_a[CHUNK-1]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (capture) begin
      a_d     = a;
      b_d     = b;
      mode_d  = mode;
      carry_d = mode;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: hand-computed vector table on the CHUNK=4 instance,
// back-to-back and reset corner sequences, and a model sweep across CHUNK = 1/2/4/8.
module tb_addsub_seq;

  localparam int M = 2;  // index of the WIDTH=8, CHUNK=4 instance

  logic       clk, rst_n, start, mode;
  logic [7:0] a, b;
  logic [7:0] sw_sum [4];
  logic       sw_c [4], sw_o [4], sw_busy [4], sw_done [4];

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned nj [4] = '{8, 4, 2, 1};

  addsub_seq #(.WIDTH(8), .CHUNK(1)) u_c1 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .a(a), .b(b), .sum(sw_sum[0]), .c_out(sw_c[0]), .ovf(sw_o[0]), .busy(sw_busy[0]), .done(sw_done[0]));
  addsub_seq #(.WIDTH(8), .CHUNK(2)) u_c2 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .a(a), .b(b), .sum(sw_sum[1]), .c_out(sw_c[1]), .ovf(sw_o[1]), .busy(sw_busy[1]), .done(sw_done[1]));
  addsub_seq #(.WIDTH(8), .CHUNK(4)) dut  (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .a(a), .b(b), .sum(sw_sum[2]), .c_out(sw_c[2]), .ovf(sw_o[2]), .busy(sw_busy[2]), .done(sw_done[2]));
  addsub_seq #(.WIDTH(8), .CHUNK(8)) u_c8 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .a(a), .b(b), .sum(sw_sum[3]), .c_out(sw_c[3]), .ovf(sw_o[3]), .busy(sw_busy[3]), .done(sw_done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Independent reference: integer arithmetic; returns {c_out, ovf, sum}.
  function automatic logic [9:0] model(input logic m, input logic [7:0] x, input logic [7:0] y);
    int ua, ub, sa, sb, r, sr;
    logic c, o;
    logic [7:0] s;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    if (m) begin
      r = ua - ub;  sr = sa - sb;  c = (ua < ub);
    end else begin
      r = ua + ub;  sr = sa + sb;  c = (r > 255);
    end
    o = (sr > 127) || (sr < -128);
    s = 8'(r);
    return {c, o, s};
  endfunction

  typedef struct {
    logic       m;
    logic [7:0] x, y, s;
    logic       c, o;
  } vec_t;

  vec_t vt [10];
  logic [7:0] prev_sum;
  logic [9:0] ex;
  logic [9:0] exq [4];
  logic [7:0] vals [16];
  logic [3:0] seen;

  task automatic run_op(input logic m, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    mode = m; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ex = model(m, x, y);
    seen = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) begin
        if (sw_done[j] && !seen[j]) begin
          seen[j] = 1'b1;
          chk($sformatf("sweep_lat_n%0d", nj[j]), 8'(cyc), 8'(nj[j]));
          chk($sformatf("sweep_sum_n%0d m%0d %0h %0h", nj[j], m, x, y), sw_sum[j], ex[7:0]);
          chk($sformatf("sweep_c_n%0d m%0d %0h %0h", nj[j], m, x, y), 8'(sw_c[j]), 8'(ex[9]));
          chk($sformatf("sweep_ovf_n%0d m%0d %0h %0h", nj[j], m, x, y), 8'(sw_o[j]), 8'(ex[8]));
        end
      end
      if (&seen) break;
    end
    for (int j = 0; j < 4; j++)
      if (!seen[j]) chk($sformatf("sweep_timeout_n%0d", nj[j]), 8'(seen[j]), 8'd1);
  endtask

  initial begin
    vt[0] = '{1'b0, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h02, 8'h03, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vt[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vt[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vt[6] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0};
    vt[7] = '{1'b1, 8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
    vt[8] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vt[9] = '{1'b1, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h3F, 8'h40, 8'h7E,
             8'h7F, 8'h80, 8'h81, 8'hA5, 8'hC0, 8'hFE, 8'hFF, 8'h5A};

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sw_sum[M], 8'h00);
    chk("rst_c", 8'(sw_c[M]), 8'h00);
    chk("rst_ovf", 8'(sw_o[M]), 8'h00);
    chk("rst_busy", 8'(sw_busy[M]), 8'h00);
    chk("rst_done", 8'(sw_done[M]), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: timing, result, and hold of the previous result through RUN/IDLE.
    prev_sum = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mode = vt[i].m; a = vt[i].x; b = vt[i].y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = ~a; b = b + 8'h5C; mode = ~mode;
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("tbl%0d_busy%0d", i, r), 8'(sw_busy[M]), 8'h01);
        chk($sformatf("tbl%0d_nodone%0d", i, r), 8'(sw_done[M]), 8'h00);
        chk($sformatf("tbl%0d_hold%0d", i, r), sw_sum[M], prev_sum);
        @(posedge clk); #1;
      end
      chk($sformatf("tbl%0d_done", i), 8'(sw_done[M]), 8'h01);
      chk($sformatf("tbl%0d_busy_done", i), 8'(sw_busy[M]), 8'h00);
      chk($sformatf("tbl%0d_sum", i), sw_sum[M], vt[i].s);
      chk($sformatf("tbl%0d_c", i), 8'(sw_c[M]), 8'(vt[i].c));
      chk($sformatf("tbl%0d_ovf", i), 8'(sw_o[M]), 8'(vt[i].o));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done_1cyc", i), 8'(sw_done[M]), 8'h00);
      chk($sformatf("tbl%0d_idle_hold", i), sw_sum[M], vt[i].s);
      prev_sum = vt[i].s;
      repeat (10) @(posedge clk);
    end

    // Back-to-back: start held high, operands change every cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = 8'(i * 37 + 11); b = 8'(i * 53 + 200); mode = i[0]; start = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_done", i), 8'(sw_done[M]), 8'((i % 3) == 2));
      chk($sformatf("b2b%0d_busy", i), 8'(sw_busy[M]), 8'((i % 3) != 2));
      if ((i % 3) == 2) begin
        ex = model(1'(i - 2), 8'((i - 2) * 37 + 11), 8'((i - 2) * 53 + 200));
        chk($sformatf("b2b%0d_sum", i), sw_sum[M], ex[7:0]);
        chk($sformatf("b2b%0d_c", i), 8'(sw_c[M]), 8'(ex[9]));
        chk($sformatf("b2b%0d_ovf", i), 8'(sw_o[M]), 8'(ex[8]));
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);

    // Reset mid-RUN: outputs clear without a clock edge, no done afterwards.
    run_op(1'b0, 8'h80, 8'h81);
    @(negedge clk);
    a = 8'h12; b = 8'h34; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_busy", 8'(sw_busy[M]), 8'h01);
    chk("mid_sum_held", sw_sum[M], 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", sw_sum[M], 8'h00);
    chk("arst_c", 8'(sw_c[M]), 8'h00);
    chk("arst_ovf", 8'(sw_o[M]), 8'h00);
    chk("arst_busy", 8'(sw_busy[M]), 8'h00);
    chk("arst_done", 8'(sw_done[M]), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_nodone%0d", i), 8'(sw_done[M]), 8'h00);
      chk($sformatf("post_rst_idle%0d", i), 8'(sw_busy[M]), 8'h00);
    end

    // Model sweep over boundary values and random pairs on all four chunk sizes.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          run_op(1'(m), vals[i], vals[j]);
    for (int k = 0; k < 400; k++)
      run_op(1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
